// File: rtl/pixel_byte_serializer.sv
// Buffers RGB pixels in a small FIFO and serialises each one as R,G,B bytes
// (or the red byte only in gray mode) to a UART transmitter handshake.
module pixel_byte_serializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    input  logic [7:0]                    pix_red,
    input  logic [7:0]                    pix_green,
    input  logic [7:0]                    pix_blue,
    output logic                          pix_ready,
    input  logic                          gray_mode,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   pixels_sent,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_GAP   = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [23:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [7:0]      red_r;
    logic [7:0]      green_r;
    logic [7:0]      blue_r;
    logic            gray_r;
    logic [1:0]      byte_idx_r;
    logic [7:0]      tx_data_r;
    logic            tx_start_r;
    logic [15:0]     sent_r;

    logic            push_s;
    logic            pop_s;
    logic            load_s;
    logic            fire_s;
    logic            advance_s;
    logic            finish_s;
    logic            last_s;
    logic            not_empty_s;

    assign not_empty_s = (count_r != {CW{1'b0}});
    assign pix_ready   = (count_r != CW'(FIFO_DEPTH));
    assign push_s      = pix_valid && pix_ready;
    assign last_s      = (byte_idx_r == 2'd2) || gray_r;

    assign tx_data     = tx_data_r;
    assign tx_start    = tx_start_r;
    assign fifo_count  = count_r;
    assign pixels_sent = sent_r;
    assign busy        = (state_r != ST_IDLE) || not_empty_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (not_empty_s) state_next_s = ST_LOAD;  else state_next_s = ST_IDLE;
            ST_LOAD:  state_next_s = ST_START;
            ST_START: if (!tx_busy)    state_next_s = ST_GAP;   else state_next_s = ST_START;
            ST_GAP:   state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (tx_busy) begin
                    state_next_s = ST_WAIT;
                end else if (last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM action decode, consumed by the datapath registers below
    always_comb begin
        pop_s     = 1'b0;
        load_s    = 1'b0;
        fire_s    = 1'b0;
        advance_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            ST_IDLE:  if (not_empty_s) pop_s = 1'b1; else pop_s = 1'b0;
            ST_LOAD:  load_s = 1'b1;
            ST_START: if (!tx_busy) fire_s = 1'b1; else fire_s = 1'b0;
            ST_WAIT: begin
                if (!tx_busy) begin
                    finish_s  = last_s;
                    advance_s = !last_s;
                end else begin
                    finish_s  = 1'b0;
                    advance_s = 1'b0;
                end
            end
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {pix_red, pix_green, pix_blue};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Holding registers for the pixel in flight, including its latched gray bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_r      <= 8'h00;
            green_r    <= 8'h00;
            blue_r     <= 8'h00;
            gray_r     <= 1'b0;
            byte_idx_r <= 2'd0;
        end else if (pop_s) begin
            {red_r, green_r, blue_r} <= mem_r[rd_ptr_r];
            gray_r     <= gray_mode;
            byte_idx_r <= 2'd0;
        end else if (advance_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
        end
    end

    // Transmit byte, start pulse and completed-pixel counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            sent_r     <= 16'h0000;
        end else begin
            tx_start_r <= fire_s;
            if (load_s) begin
                case (byte_idx_r)
                    2'd0:    tx_data_r <= red_r;
                    2'd1:    tx_data_r <= green_r;
                    2'd2:    tx_data_r <= blue_r;
                    default: tx_data_r <= red_r;
                endcase
            end
            if (finish_s) sent_r <= sent_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_byte_serializer.sv
// Directed bench for pixel_byte_serializer with a behavioural UART busy model.
module tb_pixel_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_red = 8'h00;
    logic [7:0]  pix_green = 8'h00;
    logic [7:0]  pix_blue = 8'h00;
    logic        pix_ready;
    logic        gray_mode = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  fifo_count;
    logic [15:0] pixels_sent;
    logic        busy;

    int   busy_len = 10;
    bit   busy_stuck = 1'b0;
    int   busy_cnt = 0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_total = 0;
    int   consec = 0;
    bit   prev_start = 1'b0;
    int   push_cyc = 0;
    int   base = 0;
    int   start_cyc_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    pixel_byte_serializer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .pix_ready(pix_ready), .gray_mode(gray_mode), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .fifo_count(fifo_count),
        .pixels_sent(pixels_sent), .busy(busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = busy_stuck || (busy_cnt != 0);

    // UART model and byte monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_start <= tx_start;
        if (tx_start && prev_start) consec <= consec + 1;
        if (tx_start) begin
            busy_cnt <= busy_len;
            got_q.push_back(tx_data);
            start_cyc_q.push_back(cyc);
            start_total <= start_total + 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        exp_q.delete();
        start_cyc_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int n = 0;
        pix_valid = 1'b1;
        pix_red = r; pix_green = g; pix_blue = b;
        while (!pix_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_timeout", {31'd0, pix_ready}, 32'd1);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_bytes(input string tag);
        check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check_eq("rst_pixels_sent", {16'd0, pixels_sent}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", {31'd0, pix_ready}, 32'd1);

        // RGB pixel with a 10-cycle transmitter
        clear_log();
        busy_len = 10;
        push_pixel(8'h12, 8'h34, 8'h56);
        push_cyc = cyc;
        wait_idle();
        check_eq("first_start_latency", (start_cyc_q.size() > 0) ? start_cyc_q[0] - push_cyc : -1, 32'd3);
        exp_q = '{8'h12, 8'h34, 8'h56};
        check_bytes("rgb");
        check_eq("rgb_sent", {16'd0, pixels_sent}, 32'd1);
        check_eq("rgb_busy", {31'd0, busy}, 32'd0);

        // Gray pixel: red byte only
        clear_log();
        gray_mode = 1'b1;
        busy_len = 4;
        push_pixel(8'hAA, 8'h00, 8'h00);
        wait_idle();
        exp_q = '{8'hAA};
        check_bytes("gray");
        check_eq("gray_sent", {16'd0, pixels_sent}, 32'd2);

        // gray_mode changed mid-pixel only affects the next popped pixel
        clear_log();
        base = start_total;
        push_pixel(8'h11, 8'h22, 8'h33);
        n = 0;
        while (start_total == base && n < 200) begin @(negedge clk); n++; end
        gray_mode = 1'b0;
        push_pixel(8'h44, 8'h55, 8'h66);
        wait_idle();
        exp_q = '{8'h11, 8'h44, 8'h55, 8'h66};
        check_bytes("gray_switch");
        check_eq("gray_switch_sent", {16'd0, pixels_sent}, 32'd4);

        // Back-pressure with the transmitter stuck busy
        clear_log();
        busy_stuck = 1'b1;
        for (int i = 0; i < 5; i++)
            push_pixel(8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3));
        check_eq("full_count", {29'd0, fifo_count}, 32'd4);
        check_eq("full_ready", {31'd0, pix_ready}, 32'd0);
        pix_valid = 1'b1;
        pix_red = 8'h51; pix_green = 8'h52; pix_blue = 8'h53;
        repeat (4) @(negedge clk);
        check_eq("full_held_count", {29'd0, fifo_count}, 32'd4);
        busy_stuck = 1'b0;
        n = 0;
        while (!pix_ready && n < 500) begin @(negedge clk); n++; end
        check_eq("full_release_ready", {31'd0, pix_ready}, 32'd1);
        @(negedge clk);
        pix_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(8'(16 * i + 1));
            exp_q.push_back(8'(16 * i + 2));
            exp_q.push_back(8'(16 * i + 3));
        end
        check_bytes("full");
        check_eq("full_sent", {16'd0, pixels_sent}, 32'd10);

        // Push and pop in the same cycle with two pixels queued
        clear_log();
        busy_len = 3;
        push_pixel(8'hB1, 8'hB2, 8'hB3);
        push_pixel(8'hC1, 8'hC2, 8'hC3);
        push_pixel(8'hD1, 8'hD2, 8'hD3);
        n = 0;
        while (pixels_sent != 16'd11 && n < 500) begin @(negedge clk); n++; end
        check_eq("pp_pre_count", {29'd0, fifo_count}, 32'd2);
        pix_valid = 1'b1;
        pix_red = 8'hE1; pix_green = 8'hE2; pix_blue = 8'hE3;
        @(negedge clk);
        pix_valid = 1'b0;
        check_eq("pp_post_count", {29'd0, fifo_count}, 32'd2);
        wait_idle();
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hC1, 8'hC2, 8'hC3,
                  8'hD1, 8'hD2, 8'hD3, 8'hE1, 8'hE2, 8'hE3};
        check_bytes("pp");
        check_eq("pp_sent", {16'd0, pixels_sent}, 32'd14);

        // Reset after the green byte's tx_start with two pixels queued
        clear_log();
        busy_len = 10;
        base = start_total;
        push_pixel(8'hA1, 8'hA2, 8'hA3);
        push_pixel(8'hA4, 8'hA5, 8'hA6);
        push_pixel(8'hA7, 8'hA8, 8'hA9);
        n = 0;
        while (start_total < base + 2 && n < 500) begin @(negedge clk); n++; end
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check_eq("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        check_eq("mid_rst_sent", {16'd0, pixels_sent}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = start_total;
        @(negedge clk);
        check_eq("mid_rst_ready", {31'd0, pix_ready}, 32'd1);
        repeat (40) @(negedge clk);
        check_eq("mid_rst_no_start", start_total, base);
        clear_log();
        gray_mode = 1'b1;
        push_pixel(8'h77, 8'h00, 8'h00);
        wait_idle();
        exp_q = '{8'h77};
        check_bytes("post_rst");
        check_eq("post_rst_sent", {16'd0, pixels_sent}, 32'd1);

        // pixels_sent wraps from 65535 to 0
        clear_log();
        force dut.sent_r = 16'hFFFF;
        @(negedge clk);
        release dut.sent_r;
        push_pixel(8'hDD, 8'h00, 8'h00);
        wait_idle();
        exp_q = '{8'hDD};
        check_bytes("wrap");
        check_eq("wrap_sent", {16'd0, pixels_sent}, 32'd0);

        check_eq("no_back_to_back_start", consec, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
